// File: rtl/iob_dbus_wbuf.sv
// iob_dbus_wbuf: posted-write buffer on the CPU IOb data bus. Writes are acked on FIFO entry, reads wait for drain.
// Define IOB_DBUS_WBUF_STATS_EN to add the stall_cnt / wr_cnt performance counter ports.
module iob_dbus_wbuf #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned WBUF_AW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                u_valid,
    input  logic [ADDR_W-1:0]   u_addr,
    input  logic [DATA_W-1:0]   u_wdata,
    input  logic [DATA_W/8-1:0] u_wstrb,
    output logic [DATA_W-1:0]   u_rdata,
    output logic                u_ready,
    output logic                d_valid,
    output logic [ADDR_W-1:0]   d_addr,
    output logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W/8-1:0] d_wstrb,
    input  logic [DATA_W-1:0]   d_rdata,
    input  logic                d_ready,
    output logic                wbuf_empty
`ifdef IOB_DBUS_WBUF_STATS_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         wr_cnt
`endif
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = WBUF_AW + 1;
    localparam int unsigned DEPTH  = 2 ** WBUF_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];
    logic [STRB_W-1:0] mem_wstrb [DEPTH];

    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, rd_ptr_inc;
    logic [WBUF_AW-1:0] head_idx, next_idx, wr_idx;
    logic fifo_empty_c, fifo_full_c, fifo_more_c;
    logic is_write_c, push_c, pop_c, rd_accept_c, rd_done_c;

    logic                d_valid_nxt, u_ready_nxt, wbuf_empty_nxt;
    logic [ADDR_W-1:0]   d_addr_nxt;
    logic [DATA_W-1:0]   d_wdata_nxt, u_rdata_nxt;
    logic [STRB_W-1:0]   d_wstrb_nxt;

    // FIFO status and handshake qualifiers; u_ready doubles as the ack flag
    always_comb begin
        rd_ptr_inc   = rd_ptr + PTR_W'(1);
        head_idx     = rd_ptr[WBUF_AW-1:0];
        next_idx     = rd_ptr_inc[WBUF_AW-1:0];
        wr_idx       = wr_ptr[WBUF_AW-1:0];
        fifo_empty_c = (wr_ptr == rd_ptr);
        fifo_full_c  = (wr_ptr[WBUF_AW] != rd_ptr[WBUF_AW]) &&
                       (wr_ptr[WBUF_AW-1:0] == rd_ptr[WBUF_AW-1:0]);
        fifo_more_c  = (rd_ptr_inc != wr_ptr);
        is_write_c   = |u_wstrb;
        pop_c        = (state == WR) && d_ready;
        rd_done_c    = (state == RD) && d_ready;
        push_c       = u_valid && is_write_c && !u_ready && (!fifo_full_c || pop_c);
        rd_accept_c  = u_valid && !is_write_c && !u_ready && fifo_empty_c && (state == IDLE);
        wr_ptr_nxt   = wr_ptr + PTR_W'(push_c);
        rd_ptr_nxt   = rd_ptr + PTR_W'(pop_c);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; queued writes win over a waiting read
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty_c) begin
                    state_nxt = WR;
                end else if (rd_accept_c) begin
                    state_nxt = RD;
                end
            end
            WR: begin
                if (pop_c && !fifo_more_c) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                if (d_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        d_valid_nxt    = d_valid;
        d_addr_nxt     = d_addr;
        d_wdata_nxt    = d_wdata;
        d_wstrb_nxt    = d_wstrb;
        u_ready_nxt    = push_c || rd_done_c;
        u_rdata_nxt    = u_rdata;
        wbuf_empty_nxt = (wr_ptr_nxt == rd_ptr_nxt) && (state_nxt == IDLE);
        if (push_c) begin
            u_rdata_nxt = '0;
        end else if (rd_done_c) begin
            u_rdata_nxt = d_rdata;
        end
        case (state)
            IDLE: begin
                if (!fifo_empty_c) begin
                    d_valid_nxt = 1'b1;
                    d_addr_nxt  = mem_addr[head_idx];
                    d_wdata_nxt = mem_wdata[head_idx];
                    d_wstrb_nxt = mem_wstrb[head_idx];
                end else if (rd_accept_c) begin
                    d_valid_nxt = 1'b1;
                    d_addr_nxt  = u_addr;
                    d_wstrb_nxt = '0;
                end
            end
            WR: begin
                if (pop_c) begin
                    if (fifo_more_c) begin
                        d_addr_nxt  = mem_addr[next_idx];
                        d_wdata_nxt = mem_wdata[next_idx];
                        d_wstrb_nxt = mem_wstrb[next_idx];
                    end else begin
                        d_valid_nxt = 1'b0;
                    end
                end
            end
            RD: begin
                if (d_ready) begin
                    d_valid_nxt = 1'b0;
                end
            end
            default: d_valid_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_valid    <= 1'b0;
            d_addr     <= '0;
            d_wdata    <= '0;
            d_wstrb    <= '0;
            u_ready    <= 1'b0;
            u_rdata    <= '0;
            wbuf_empty <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            d_valid    <= d_valid_nxt;
            d_addr     <= d_addr_nxt;
            d_wdata    <= d_wdata_nxt;
            d_wstrb    <= d_wstrb_nxt;
            u_ready    <= u_ready_nxt;
            u_rdata    <= u_rdata_nxt;
            wbuf_empty <= wbuf_empty_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
        end
    end

    // FIFO storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_addr[wr_idx]  <= u_addr;
            mem_wdata[wr_idx] <= u_wdata;
            mem_wstrb[wr_idx] <= u_wstrb;
        end
    end

`ifdef IOB_DBUS_WBUF_STATS_EN
    logic stall_c;
    assign stall_c = u_valid && !u_ready && !push_c && !rd_accept_c;

    // saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            wr_cnt    <= '0;
        end else begin
            if (stall_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (push_c && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iob_dbus_wbuf.sv
// Scoreboard bench for iob_dbus_wbuf: upstream/downstream expectations come from a word-array memory model.
// Build with IOB_DBUS_WBUF_STATS_EN defined to also cover the counter ports.
module tb_iob_dbus_wbuf;

    logic        clk;
    logic        rst;
    logic        u_valid;
    logic [31:0] u_addr;
    logic [31:0] u_wdata;
    logic [3:0]  u_wstrb;
    logic [31:0] u_rdata;
    logic        u_ready;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        wbuf_empty;
`ifdef IOB_DBUS_WBUF_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] wr_cnt;
`endif

    iob_dbus_wbuf #(
        .ADDR_W (32),
        .DATA_W (32),
        .WBUF_AW(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .u_valid   (u_valid),
        .u_addr    (u_addr),
        .u_wdata   (u_wdata),
        .u_wstrb   (u_wstrb),
        .u_rdata   (u_rdata),
        .u_ready   (u_ready),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .wbuf_empty(wbuf_empty)
`ifdef IOB_DBUS_WBUF_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } dreq_t;

    int          checks = 0;
    int          errors = 0;
    dreq_t       exp_down[$];
    logic [31:0] exp_up[$];
    logic [31:0] ref_mem[256];
    logic [31:0] dmem[256];
    bit          resp_en = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          down_cnt = 0;
    int          tb_stall_cyc = 0;
    int          tb_wr_acked = 0;
    int          last_wait = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // what the bus should show for one request, from the upstream program-order view of memory
    task automatic expect_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dreq_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        exp_down.push_back(e);
        if (s != 4'd0) begin
            ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
            exp_up.push_back(32'd0);
        end else begin
            exp_up.push_back(ref_mem[a[9:2]]);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int max_wait, output int waited, output bit acked);
        u_addr  = a;
        u_wdata = d;
        u_wstrb = s;
        u_valid = 1'b1;
        acked   = 1'b0;
        waited  = 0;
        while (!acked && waited < max_wait) begin
            @(posedge clk);
            #1;
            waited++;
            if (u_ready) acked = 1'b1;
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int gap);
        int w;
        bit ok;
        expect_req(a, d, s);
        issue(a, d, s, 300, w, ok);
        check("req_ack_timeout", 32'(ok), 32'd1);
        if (ok && s != 4'd0) tb_wr_acked++;
        last_wait = w;
        u_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!wbuf_empty && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(wbuf_empty), 32'd1);
    endtask

    // upstream monitor: every u_ready pulse consumes one expected response
    initial begin
        forever begin
            @(negedge clk);
            if (rst && u_ready) begin
                check("u_ready_expected", 32'(exp_up.size() != 0), 32'd1);
                if (exp_up.size() != 0) check("u_rdata", u_rdata, exp_up.pop_front());
            end
        end
    end

    // cycles the master waits without its request being taken (acceptance cycles removed later)
    initial begin
        forever begin
            @(negedge clk);
            if (rst && u_valid && !u_ready) tb_stall_cyc++;
        end
    end

    // downstream memory: random latency, checks order, payload and hold stability
    initial begin
        dreq_t got;
        dreq_t e;
        int    lat;
        d_ready = 1'b0;
        d_rdata = 32'd0;
        forever begin
            @(negedge clk);
            d_ready = 1'b0;
            d_rdata = $urandom;
            if (resp_en && rst && d_valid) begin
                got.addr = d_addr;
                got.data = d_wdata;
                got.strb = d_wstrb;
                lat = int'($urandom_range(32'(lat_hi), 32'(lat_lo)));
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    check("d_hold_valid", 32'(d_valid), 32'd1);
                    check("d_hold_addr", d_addr, got.addr);
                    check("d_hold_strb", 32'(d_wstrb), 32'(got.strb));
                end
                check("d_req_expected", 32'(exp_down.size() != 0), 32'd1);
                if (exp_down.size() != 0) begin
                    e = exp_down.pop_front();
                    check("d_addr", got.addr, e.addr);
                    check("d_wstrb", 32'(got.strb), 32'(e.strb));
                    if (e.strb != 4'd0) check("d_wdata", got.data, e.data);
                end
                if (got.strb != 4'd0) dmem[got.addr[9:2]] = merge(dmem[got.addr[9:2]], got.data, got.strb);
                else d_rdata = dmem[got.addr[9:2]];
                d_ready = 1'b1;
                down_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        bit          ok;
        int          base;
        int          n;
        logic [31:0] a;
        logic [3:0]  s;
        int          gap;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'd0;
            dmem[i]    = 32'd0;
        end

        // reset held with a write pending upstream
        rst     = 1'b0;
        u_valid = 1'b1;
        u_addr  = 32'h100;
        u_wdata = 32'hA5A5A5A5;
        u_wstrb = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_u_ready", 32'(u_ready), 32'd0);
        check("rst_u_rdata", u_rdata, 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_d_addr", d_addr, 32'd0);
        check("rst_d_wdata", d_wdata, 32'd0);
        check("rst_d_wstrb", 32'(d_wstrb), 32'd0);
        check("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
        u_valid = 1'b0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_push", 32'(wbuf_empty), 32'd1);
        check("post_rst_d_valid", 32'(d_valid), 32'd0);

        // single write, memory answers after 3 cycles
        resp_en = 1;
        lat_lo  = 3;
        lat_hi  = 3;
        req(32'h100, 32'hDEADBEEF, 4'hF, 0);
        check("wr_ack_latency", 32'(last_wait), 32'd1);
        check("wr_pending_not_empty", 32'(wbuf_empty), 32'd0);
        wait_empty("wr_drained_empty");

        // fill the FIFO with the downstream stalled
        resp_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tb_stall_cyc = 0;
        tb_wr_acked  = 0;
        rst    = 1'b1;
        lat_lo = 0;
        lat_hi = 0;
        for (int i = 0; i < 4; i++) req(32'h140 + 32'(4 * i), $urandom, 4'hF, 0);
        expect_req(32'h150, 32'hCAFE0005, 4'hF);
        issue(32'h150, 32'hCAFE0005, 4'hF, 6, w, ok);
        check("full_write_stalls", 32'(ok), 32'd0);
        check("full_not_empty", 32'(wbuf_empty), 32'd0);
        base    = down_cnt;
        resp_en = 1;
        issue(32'h150, 32'hCAFE0005, 4'hF, 100, w, ok);
        check("full_write_released", 32'(ok), 32'd1);
        if (ok) tb_wr_acked++;
        check("ack_after_first_pop", 32'(down_cnt - base), 32'd1);
        u_valid = 1'b0;
        wait_empty("full_drained_empty");
`ifdef IOB_DBUS_WBUF_STATS_EN
        @(negedge clk);
        check("stats_wr_cnt", wr_cnt, 32'(tb_wr_acked));
        check("stats_stall_cnt", stall_cnt, 32'(tb_stall_cyc - tb_wr_acked));
`endif

        // read-after-write ordering with memory latency 2
        lat_lo = 2;
        lat_hi = 2;
        req(32'h200, 32'h12345678, 4'hF, 0);
        req(32'h200, 32'd0, 4'h0, 0);

        // read with an empty FIFO, d_ready one cycle after d_valid
        @(posedge clk);
        #1;
        lat_lo = 1;
        lat_hi = 1;
        req(32'h100, 32'd0, 4'h0, 0);
        check("rd_latency", 32'(last_wait), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rd_no_second_dvalid", 32'(d_valid), 32'd0);
        end

        // reset while writes are in flight and queued
        resp_en = 0;
        @(posedge clk);
        #1;
        req(32'h3F0, 32'h11111111, 4'hF, 0);
        req(32'h3F4, 32'h22222222, 4'hF, 0);
        req(32'h3F8, 32'h33333333, 4'hF, 0);
        n = 0;
        while (!d_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wr_inflight_before_rst", 32'(d_valid), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_d_valid", 32'(d_valid), 32'd0);
        check("abort_empty", 32'(wbuf_empty), 32'd1);
        rst = 1'b1;
        exp_down.delete();
        exp_up.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
        resp_en = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_more_writes", 32'(d_valid), 32'd0);
        end

        // randomized mix over a small address window so reads hit recent writes
        @(posedge clk);
        #1;
        for (int k = 0; k < 250; k++) begin
            lat_lo = 0;
            lat_hi = ((k / 50) % 2 == 1) ? 8 : 2;
            a   = 32'h100 + (32'($urandom_range(7, 0)) << 2);
            gap = int'($urandom_range(2, 0));
            if ($urandom_range(9, 0) < 3) begin
                req(a, 32'd0, 4'h0, gap);
            end else begin
                s = 4'($urandom_range(15, 1));
                req(a, $urandom, s, gap);
            end
        end
        wait_empty("final_drained_empty");
        repeat (3) @(negedge clk);
        check("final_up_queue_empty", 32'(exp_up.size()), 32'd0);
        check("final_down_queue_empty", 32'(exp_down.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
